// File: rtl/cam_i2c_init_seq_if.sv
// cam_i2c_init_seq_if: write-request bundle between the init
// sequencer (master) and the i2c_core single-byte master (slave).
interface cam_i2c_init_seq_if;
  logic       i2c_rqt;
  logic       cmd;
  logic [6:0] addr_dev;
  logic [7:0] addr_reg_H;
  logic [7:0] addr_reg_L;
  logic [7:0] data_wr_H;
  logic [7:0] data_wr_L;
  logic       i2c_done;

  modport master (
    output i2c_rqt, cmd, addr_dev,
    output addr_reg_H, addr_reg_L,
    output data_wr_H, data_wr_L,
    input  i2c_done
  );

  modport slave (
    input  i2c_rqt, cmd, addr_dev,
    input  addr_reg_H, addr_reg_L,
    input  data_wr_H, data_wr_L,
    output i2c_done
  );
endinterface

// File: rtl/cam_i2c_init_seq.sv
// cam_i2c_init_seq: walks a sensor register ROM and issues one
// i2c_core write per entry, with delays, retry and reset-pin control.
module cam_i2c_init_seq #(
  parameter logic [6:0] DEV_ADDR    = 7'h36,
  parameter int          ROM_AW      = 8,
  parameter int          PWRUP_CYC   = 1000000,
  parameter int          DLY_UNIT    = 100000,
  parameter int          RQT_HOLD    = 8,
  parameter int          TIMEOUT_CYC = 2000000,
  parameter int          MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  cam_i2c_init_seq_if.master i2c,
  output logic              cam_rst_n,
  output logic              busy,
  output logic              init_done,
  output logic              init_err,
  output logic [ROM_AW-1:0] err_index
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PWR_LO = 4'd1;
  localparam logic [3:0] S_PWR_HI = 4'd2;
  localparam logic [3:0] S_FETCH  = 4'd3;
  localparam logic [3:0] S_DECODE = 4'd4;
  localparam logic [3:0] S_REQ    = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_GAP    = 4'd7;
  localparam logic [3:0] S_DELAY  = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic [3:0] S_ERROR  = 4'd10;

  localparam logic [31:0] PWR_LAST  = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] HOLD_LAST = 32'(RQT_HOLD - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'd15;
  localparam logic [ROM_AW-1:0] IDX_LAST = {ROM_AW{1'b1}};

  logic [3:0]        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [7:0]        retry_q, retry_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [ROM_AW-1:0] eidx_q, eidx_d;
  logic [15:0]       areg_q, areg_d;
  logic [7:0]        dat_q, dat_d;
  logic              start_q;
  logic              rqt_q, rqt_d;
  logic              camr_q, camr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        start_edge;
  logic [31:0] dly;

  assign start_edge = start & ~start_q;
  assign dly        = 32'(rom_data[7:0]) * 32'(DLY_UNIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    eidx_d  = eidx_q;
    areg_d  = areg_q;
    dat_d   = dat_q;
    rqt_d   = rqt_q;
    camr_d  = camr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_PWR_LO;
          busy_d  = 1'b1;
          camr_d  = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          eidx_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_PWR_LO: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          camr_d  = 1'b1;
          state_d = S_PWR_HI;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_PWR_HI: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data[23:8] == 16'hFFFE) begin
          state_d = S_DONE;
        end else if (rom_data[23:8] == 16'hFFFF) begin
          cnt_d   = dly;
          state_d = S_DELAY;
        end else begin
          areg_d  = rom_data[23:8];
          dat_d   = rom_data[7:0];
          retry_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          rqt_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d = tmo_q + 32'd1;
        if (cnt_q == HOLD_LAST) begin
          rqt_d   = 1'b0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        // a completion coinciding with the timeout wins
        if (i2c.i2c_done) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < 8'(MAX_RETRY)) begin
            retry_d = retry_q + 8'd1;
            cnt_d   = '0;
            tmo_d   = '0;
            rqt_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ROM_AW'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ROM_AW'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        err_d   = 1'b1;
        eidx_d  = idx_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      eidx_q  <= '0;
      areg_q  <= '0;
      dat_q   <= '0;
      start_q <= 1'b0;
      rqt_q   <= 1'b0;
      camr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      areg_q  <= areg_d;
      dat_q   <= dat_d;
      start_q <= start;
      rqt_q   <= rqt_d;
      camr_q  <= camr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr       = idx_q;
  assign err_index      = eidx_q;
  assign cam_rst_n      = camr_q;
  assign busy           = busy_q;
  assign init_done      = done_q;
  assign init_err       = err_q;
  assign i2c.i2c_rqt    = rqt_q;
  assign i2c.cmd        = 1'b1;
  assign i2c.addr_dev   = DEV_ADDR;
  assign i2c.addr_reg_H = areg_q[15:8];
  assign i2c.addr_reg_L = areg_q[7:0];
  assign i2c.data_wr_H  = dat_q;
  assign i2c.data_wr_L  = 8'h00;

endmodule

// File: tb/tb_cam_i2c_init_seq.sv
// tb_cam_i2c_init_seq: directed tables with an i2c_core response model
// and a queue scoreboard checked by an independent monitor.
module tb_cam_i2c_init_seq;
  localparam int AW = 3;
  localparam int P  = 20;
  localparam int DU = 10;
  localparam int RH = 8;
  localparam int TO = 1000;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] err_index;
  logic [23:0]   rom_data;
  logic          cam_rst_n, busy, init_done, init_err;

  cam_i2c_init_seq_if bus();

  cam_i2c_init_seq #(
    .DEV_ADDR(7'h36), .ROM_AW(AW), .PWRUP_CYC(P),
    .DLY_UNIT(DU), .RQT_HOLD(RH), .TIMEOUT_CYC(TO),
    .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c(bus), .cam_rst_n(cam_rst_n), .busy(busy),
    .init_done(init_done), .init_err(init_err),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [8];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // i2c_core model: done pulse 500 cycles after each rqt rising edge
  int   pend = 0;
  int   drop_n = 0;
  bit   silent = 0;
  logic m_prev = 1'b0;
  initial bus.i2c_done = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.i2c_done = 1'b0;
    if (!rst_n) begin
      pend = 0;
      m_prev = 1'b0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) bus.i2c_done = 1'b1;
      end
      if (bus.i2c_rqt && !m_prev) begin
        if (drop_n > 0) drop_n--;
        else if (!(silent && bus.addr_reg_H == 8'h38)) pend = 500;
      end
      m_prev = bus.i2c_rqt;
    end
  end

  logic [23:0] exp_tx[$];
  logic [5:0]  exp_res[$];
  int          rqt_cyc[$];
  int          done_cyc[$];
  int          busy_rise = 0;
  int          cam_rise = 0;
  int          hold_start = 0;
  int          res_cnt = 0;
  logic        rqt_p = 1'b0, busy_p = 1'b0, cam_p = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rqt_p = 1'b0;
      busy_p = 1'b0;
      cam_p = 1'b0;
    end else begin
      if (bus.i2c_rqt && !rqt_p) begin
        rqt_cyc.push_back(cyc);
        hold_start = cyc;
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rqt_unexpected: got %02h%02h%02h want none",
                   bus.addr_reg_H, bus.addr_reg_L, bus.data_wr_H);
        end else begin
          chk("rqt_payload",
              {bus.addr_reg_H, bus.addr_reg_L, bus.data_wr_H},
              exp_tx.pop_front());
          chk("rqt_const", {bus.cmd, bus.addr_dev, bus.data_wr_L},
              {1'b1, 7'h36, 8'h00});
        end
      end
      if (!bus.i2c_rqt && rqt_p) chk("rqt_hold", cyc - hold_start, RH);
      if (bus.i2c_done) done_cyc.push_back(cyc);
      if (cam_rst_n && !cam_p) cam_rise = cyc;
      if (busy && !busy_p) begin
        busy_rise = cyc;
        chk("clear_on_start", {init_done, init_err, err_index}, 0);
      end
      if (!busy && busy_p) begin
        if (exp_res.size() == 0) begin
          total++;
          bad++;
          $display("FAIL result_unexpected: got %0b want none",
                   {init_done, init_err, cam_rst_n, err_index});
        end else begin
          chk("result", {init_done, init_err, cam_rst_n, err_index},
              exp_res.pop_front());
        end
        res_cnt++;
      end
      rqt_p = bus.i2c_rqt;
      busy_p = busy;
      cam_p = cam_rst_n;
    end
  end

  task automatic check_reset(string nm);
    logic [50:0] exp_v;
    exp_v = {5'b0, 3'b0, 3'b0, 24'h0, 1'b1, 7'h36, 8'h00};
    chk(nm, {bus.i2c_rqt, cam_rst_n, busy, init_done, init_err,
             err_index, rom_addr, bus.addr_reg_H, bus.addr_reg_L,
             bus.data_wr_H, bus.cmd, bus.addr_dev, bus.data_wr_L},
        exp_v);
  endtask

  task automatic load(logic [23:0] a, logic [23:0] b,
                      logic [23:0] c, logic [23:0] d);
    for (int i = 0; i < 8; i++) rom[i] = 24'hFFFE00;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    rqt_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int n0, string nm);
    int k = 0;
    while (res_cnt == n0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (res_cnt == n0) begin
      total++;
      bad++;
      $display("FAIL %s: no completion after %0d cycles", nm, k);
    end
    chk({nm, "_tx_left"}, exp_tx.size(), 0);
  endtask

  task automatic wait_rqts(int n, string nm);
    int k = 0;
    while (rqt_cyc.size() < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_rqts_seen"}, rqt_cyc.size() >= n, 1);
  endtask

  int n0;

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset_init");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy, cam_rst_n, bus.i2c_rqt}, 0);

    // two writes then end marker
    load(24'h300882, 24'h310303, 24'hFFFE00, 24'hFFFE00);
    exp_tx.push_back(24'h300882);
    exp_tx.push_back(24'h310303);
    exp_res.push_back(6'b101_000);
    n0 = res_cnt;
    start_pulse();
    wait_done(n0, "basic");
    chk("basic_pwr_lo", cam_rise - busy_rise, P);
    chk("basic_first_rqt", rqt_cyc[0] - busy_rise, 2 * P + 2);
    chk("basic_rqt_count", rqt_cyc.size(), 2);

    // delay entry of 5 units between the writes
    load(24'h300882, 24'hFFFF05, 24'h310303, 24'hFFFE00);
    exp_tx.push_back(24'h300882);
    exp_tx.push_back(24'h310303);
    exp_res.push_back(6'b101_000);
    n0 = res_cnt;
    start_pulse();
    wait_done(n0, "delay");
    chk("delay_gap", (rqt_cyc[1] - done_cyc[0] >= 5 * DU + 16) &&
                     (rqt_cyc[1] - done_cyc[0] <= 5 * DU + 30), 1);

    // first completion dropped, retry succeeds
    load(24'h300882, 24'h310303, 24'hFFFE00, 24'hFFFE00);
    drop_n = 1;
    exp_tx.push_back(24'h300882);
    exp_tx.push_back(24'h300882);
    exp_tx.push_back(24'h310303);
    exp_res.push_back(6'b101_000);
    n0 = res_cnt;
    start_pulse();
    wait_done(n0, "retry");
    chk("retry_spacing", rqt_cyc[1] - rqt_cyc[0], TO);

    // entry 2 never answered: 1 + MR attempts, then error
    load(24'h300882, 24'h310303, 24'h382040, 24'hFFFE00);
    silent = 1;
    exp_tx.push_back(24'h300882);
    exp_tx.push_back(24'h310303);
    for (int i = 0; i <= MR; i++) exp_tx.push_back(24'h382040);
    exp_res.push_back(6'b011_010);
    n0 = res_cnt;
    start_pulse();
    wait_done(n0, "error");
    silent = 0;
    chk("error_rqt_count", rqt_cyc.size(), 2 + MR + 1);

    // full table without marker, start pulses while busy
    load(24'h301001, 24'h311104, 24'h321207, 24'h33130A);
    for (int i = 4; i < 8; i++)
      rom[i] = {8'(8'h30 + i), 8'(8'h10 + i), 8'(i * 3 + 1)};
    for (int i = 0; i < 8; i++) exp_tx.push_back(rom[i]);
    exp_res.push_back(6'b101_000);
    n0 = res_cnt;
    start_pulse();
    repeat (10) @(negedge clk);
    start_pulse();
    wait_rqts(3, "full");
    start_pulse();
    wait_done(n0, "full");
    chk("full_rom_addr_end", rom_addr, 3'd7);
    chk("full_rqt_count", rqt_cyc.size(), 8);

    // reset during WAIT of entry 1, then restart from scratch
    load(24'h300882, 24'h310303, 24'hFFFE00, 24'hFFFE00);
    exp_tx.push_back(24'h300882);
    exp_tx.push_back(24'h310303);
    start_pulse();
    wait_rqts(2, "rst");
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #2 check_reset("reset_mid");
    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    rst_n = 1'b1;
    chk("rst_tx_left", exp_tx.size(), 0);
    load(24'h300882, 24'h310303, 24'hFFFE00, 24'hFFFE00);
    exp_tx.push_back(24'h300882);
    exp_tx.push_back(24'h310303);
    exp_res.push_back(6'b101_000);
    n0 = res_cnt;
    start_pulse();
    wait_done(n0, "restart");
    chk("restart_pwr_lo", cam_rise - busy_rise, P);
    chk("restart_first_rqt", rqt_cyc[0] - busy_rise, 2 * P + 2);
    chk("res_left", exp_res.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
